// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate/ALU encodings and the ID/EX control bundle.
// Used by decode_pipe_stage and its sub-units.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Control half of the ID/EX register; XLEN-wide data fields live in the top.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_control;
  } id_ex_t;

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/decode_controller.sv
// Main and ALU control decoder for the lw/sw/R/I-ALU/beq subset.
module decode_controller
  import decode_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic       reg_write,
  output imm_src_t   imm_src,
  output logic       alu_src,
  output logic       mem_write,
  output logic       result_src,
  output logic       branch,
  output logic [2:0] alu_control
);

  alu_op_t alu_op;

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    case (op)
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
      end
      OP_STORE: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_I_ALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type funct7[5]; addi shares funct3 000 but never subtracts.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/decode_extend.sv
// Sign-extension unit for I, S and B immediates; hi = instr[31:20], lo = instr[11:7].
module decode_extend
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [11:0]     hi,
  input  logic [4:0]      lo,
  input  imm_src_t        imm_src,
  output logic [XLEN-1:0] imm_ext
);

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{(XLEN-12){hi[11]}}, hi};
      IMM_S:   imm_ext = {{(XLEN-12){hi[11]}}, hi[11:5], lo};
      IMM_B:   imm_ext = {{(XLEN-12){hi[11]}}, lo[0], hi[10:5], lo[4:1], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/decode_pipe_stage_regfile.sv
// decode_regfile: NREGS x XLEN register file, x0 hard-wired to zero, cleared on reset.
// Define DECODE_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module decode_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] a1,
  input  logic [RA_W-1:0] a2,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_active;

  assign wr_active = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_active) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (a1 == '0) ? '0 : regs[a1];
    rd2 = (a2 == '0) ? '0 : regs[a2];
`ifdef DECODE_BYPASS_EN
    if (wr_active && (wa == a1)) rd1 = wd;
    if (wr_active && (wa == a2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// RISC-V decode stage with register file, load-use hazard detect and ID/EX register.
// Optional DECODE_BYPASS_EN enables writeback-to-decode forwarding in the register file.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            valid_d,
  input  logic            reg_write_w,
  input  logic [RA_W-1:0] rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            hold_e,
  input  logic            flush_e,
  output logic            hazard_o,
  output logic            valid_e,
  output logic            reg_write_e,
  output logic            alu_src_e,
  output logic            mem_write_e,
  output logic            result_src_e,
  output logic            branch_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [RA_W-1:0] rs1_e,
  output logic [RA_W-1:0] rs2_e,
  output logic [RA_W-1:0] rd_e
);

  logic [6:0]      op;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic            reg_write_d, alu_src_d, mem_write_d, result_src_d, branch_d;
  logic [2:0]      alu_control_d;
  imm_src_t        imm_src_d;
  logic [XLEN-1:0] imm_ext_d, rd1_d, rd2_d;

  id_ex_t          ctrl_d, ctrl_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;

  assign op  = instr_d[6:0];
  assign rs1 = instr_d[15 +: RA_W];
  assign rs2 = instr_d[20 +: RA_W];
  assign rd  = instr_d[7 +: RA_W];

  decode_controller u_ctrl (
    .op          (op),
    .funct3      (instr_d[14:12]),
    .funct7_5    (instr_d[30]),
    .reg_write   (reg_write_d),
    .imm_src     (imm_src_d),
    .alu_src     (alu_src_d),
    .mem_write   (mem_write_d),
    .result_src  (result_src_d),
    .branch      (branch_d),
    .alu_control (alu_control_d)
  );

  decode_extend #(.XLEN(XLEN)) u_ext (
    .hi      (instr_d[31:20]),
    .lo      (instr_d[11:7]),
    .imm_src (imm_src_d),
    .imm_ext (imm_ext_d)
  );

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (rs1),
    .a2  (rs2),
    .we  (reg_write_w),
    .wa  (rd_w),
    .wd  (result_w),
    .rd1 (rd1_d),
    .rd2 (rd2_d)
  );

  // A load in EX whose destination feeds this instruction must wait one cycle.
  assign hazard_o = ctrl_q.valid && ctrl_q.reg_write && ctrl_q.result_src &&
                    (rd_q != '0) && valid_d &&
                    ((rd_q == rs1) || ((rd_q == rs2) && uses_rs2(op)));

  always_comb begin
    ctrl_d = '0;
    if (valid_d) begin
      ctrl_d.valid       = 1'b1;
      ctrl_d.reg_write   = reg_write_d;
      ctrl_d.alu_src     = alu_src_d;
      ctrl_d.mem_write   = mem_write_d;
      ctrl_d.result_src  = result_src_d;
      ctrl_d.branch      = branch_d;
      ctrl_d.alu_control = alu_control_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush_e || (!hold_e && hazard_o)) begin
      ctrl_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else if (!hold_e) begin
      ctrl_q     <= ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_ext_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      rd_q       <= rd;
    end
  end

  assign valid_e       = ctrl_q.valid;
  assign reg_write_e   = ctrl_q.reg_write;
  assign alu_src_e     = ctrl_q.alu_src;
  assign mem_write_e   = ctrl_q.mem_write;
  assign result_src_e  = ctrl_q.result_src;
  assign branch_e      = ctrl_q.branch;
  assign alu_control_e = ctrl_q.alu_control;
  assign rd1_e         = rd1_q;
  assign rd2_e         = rd2_q;
  assign imm_ext_e     = imm_q;
  assign pc_e          = pc_q;
  assign pc_plus4_e    = pc_plus4_q;
  assign rs1_e         = rs1_q;
  assign rs2_e         = rs2_q;
  assign rd_e          = rd_q;

endmodule
